draw_sequencer: RTL

- Controller and pixel mux between the full-screen/sprite draw units and the VGA adapter's write port.
- Each draw unit starts when its resetn is released, streams x/y/colour, and raises a sticky done flag.
- This block starts the selected units one at a time in ascending index order (background first, overlays later) and muxes the active unit onto the VGA bus.
- It generates a plot strobe aligned to valid pixels and reports completion of the whole sequence.

---
 rtl/draw_sequencer_pkg.sv | 23 ++
 rtl/lowest_set_index.sv | 24 ++
 rtl/draw_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/draw_sequencer_pkg.sv
// Shared types and constants for the draw sequencer: FSM state encoding,
// VGA pixel field widths and screen geometry.
package draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_DRAW  = 2'd2,
    ST_NEXT  = 2'd3
  } state_t;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 9;

  localparam int SCR_W   = 160;
  localparam int SCR_H   = 120;
  localparam int SCR_PIX = SCR_W * SCR_H;

  // Number of PRIME cycles before a unit's first pixel is valid.
  localparam int PRIME_CYCLES = 2;

endpackage

// File: rtl/lowest_set_index.sv
// Priority encoder: index of the lowest set bit of mask, plus a flag that
// says whether any bit was set at all.
module lowest_set_index #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] index,
  output logic          valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Starts the selected draw units one at a time (lowest index first) and muxes
// the active unit onto the VGA write port. Optional watchdog: TIMEOUT_EN.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int N_SRC          = 4,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N_SRC-1:0]   src_mask,
  input  logic [N_SRC-1:0]   src_done,
  input  logic [8*N_SRC-1:0] src_x,
  input  logic [7*N_SRC-1:0] src_y,
  input  logic [9*N_SRC-1:0] src_colour,
  output logic [N_SRC-1:0]   src_resetn,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [C_W-1:0]     vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               seq_done,
  output logic               timeout_err,
  output state_t             dbg_state
);

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_t           state, state_n;
  logic [SW-1:0]    sel, sel_n;
  logic [N_SRC-1:0] mask_q, mask_n;
  logic [N_SRC-1:0] sel_onehot, mask_rem, enc_in;
  logic [SW-1:0]    enc_idx;
  logic             enc_valid;
  logic             prime_cnt, prime_n;
  logic             seq_done_q, done_n;
  logic             unit_on, plot;
  logic             wd_hit, wd_clear, to_set;
  logic             unit_active;

  assign sel_onehot  = N_SRC'(1) << sel;
  assign mask_rem    = mask_q & ~sel_onehot;
  assign unit_active = (state == ST_PRIME) || (state == ST_DRAW);

  // IDLE picks from the incoming request; NEXT picks from what is left.
  assign enc_in = (state == ST_IDLE) ? src_mask : mask_rem;

  lowest_set_index #(
    .N (N_SRC)
  ) u_lsi (
    .mask  (enc_in),
    .index (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      sel        <= '0;
      mask_q     <= '0;
      prime_cnt  <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      mask_q     <= mask_n;
      prime_cnt  <= prime_n;
      seq_done_q <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    mask_n   = mask_q;
    prime_n  = prime_cnt;
    done_n   = 1'b0;
    unit_on  = 1'b0;
    plot     = 1'b0;
    wd_clear = 1'b0;
    to_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (enc_valid) begin
            mask_n   = src_mask;
            sel_n    = enc_idx;
            prime_n  = 1'b0;
            wd_clear = 1'b1;
            state_n  = ST_PRIME;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      ST_PRIME: begin
        unit_on = 1'b1;
        if (wd_hit) begin
          to_set  = 1'b1;
          state_n = ST_NEXT;
        end else if (prime_cnt) begin
          state_n = ST_DRAW;
        end else begin
          prime_n = 1'b1;
        end
      end
      ST_DRAW: begin
        unit_on = 1'b1;
        // The cycle that shows done still carries the unit's last pixel.
        if (src_done[sel]) begin
          plot    = 1'b1;
          state_n = ST_NEXT;
        end else if (wd_hit) begin
          to_set  = 1'b1;
          state_n = ST_NEXT;
        end else begin
          plot = 1'b1;
        end
      end
      ST_NEXT: begin
        mask_n = mask_rem;
        if (enc_valid) begin
          sel_n    = enc_idx;
          prime_n  = 1'b0;
          wd_clear = 1'b1;
          state_n  = ST_PRIME;
        end else begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

`ifdef TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_err_q;

  // Counts cycles since the current unit was started; zero in its first PRIME cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_cnt <= '0;
    end else if (wd_clear) begin
      wd_cnt <= '0;
    end else if (unit_active) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      timeout_err_q <= 1'b0;
    end else if (to_set) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign wd_hit      = unit_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;
`else
  logic unused_wd;

  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_wd   = ^{wd_clear, to_set, unit_active, (TIMEOUT_CYCLES > 0)};
`endif

  assign src_resetn = unit_on ? sel_onehot : '0;
  assign vga_plot   = plot;
  assign busy       = (state != ST_IDLE);
  assign seq_done   = seq_done_q;
  assign dbg_state  = state;

  // Pixel fields are only meaningful while vga_plot is high.
  assign vga_x      = src_x[sel*X_W +: X_W];
  assign vga_y      = src_y[sel*Y_W +: Y_W];
  assign vga_colour = src_colour[sel*C_W +: C_W];

endmodule
